cv32e40x_lsu_resp_tracker: RTL

- Parametrised successor to the LSU response filter.
- Sits between the LSU request/response path and the OBI data bus. It gates request handshakes, tracks up to DEPTH outstanding transfers in a circular buffer, and returns early responses for bufferable transfers.
- New over the previous generation: a per-transfer sideband (META) returned with each core response, a runtime early-ack disable, and a sticky capture of bus errors on early-acked (bufferable) writes for imprecise error reporting.

---
 rtl/cv32e40x_lsu_resp_tracker.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cv32e40x_lsu_resp_tracker.sv
// LSU response tracker: gates OBI request handshakes, tracks up to DEPTH outstanding transfers,
// early-acks bufferable transfers and records the first bus error seen on an early-acked one.
module cv32e40x_lsu_resp_tracker #(
  parameter int DEPTH      = 2,
  parameter int META_WIDTH = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  early_ack_en_i,
  input  logic                  core_req_valid_i,
  output logic                  core_req_ready_o,
  input  logic                  core_req_we_i,
  input  logic                  core_req_bufferable_i,
  input  logic [ADDR_WIDTH-1:0] core_req_addr_i,
  input  logic [META_WIDTH-1:0] core_req_meta_i,
  output logic                  bus_req_valid_o,
  input  logic                  bus_req_ready_i,
  input  logic                  bus_resp_valid_i,
  input  logic [31:0]           bus_resp_rdata_i,
  input  logic                  bus_resp_err_i,
  output logic                  core_resp_valid_o,
  output logic [31:0]           core_resp_rdata_o,
  output logic                  core_resp_err_o,
  output logic                  core_resp_store_o,
  output logic [META_WIDTH-1:0] core_resp_meta_o,
  output logic                  busy_o,
  output logic                  bus_busy_o,
  output logic                  wr_err_valid_o,
  output logic [ADDR_WIDTH-1:0] wr_err_addr_o,
  input  logic                  wr_err_clear_i
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic                  ent_buf  [DEPTH];
  logic                  ent_we   [DEPTH];
  logic [ADDR_WIDTH-1:0] ent_addr [DEPTH];
  logic [META_WIDTH-1:0] ent_meta [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, core_rd_q, bus_rd_q;
  logic [CNT_W-1:0] bus_cnt_q, core_cnt_q;
  logic             wr_err_valid_q;
  logic [ADDR_WIDTH-1:0] wr_err_addr_q;

  logic bus_full, accept, bus_retire, retire_buf, absorb_err;
  logic head_buf, resp_valid, resp_fwd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Fullness is judged on bus_cnt so an entry stays allocated until the bus retires it.
  assign bus_full         = (bus_cnt_q == FULL_CNT);
  assign bus_req_valid_o  = !rst && core_req_valid_i && !bus_full;
  assign core_req_ready_o = bus_req_ready_i && !bus_full;
  assign accept           = bus_req_valid_o && bus_req_ready_i;

  assign bus_retire = bus_resp_valid_i && (bus_cnt_q != '0);
  assign retire_buf = ent_buf[bus_rd_q];
  assign absorb_err = bus_retire && retire_buf && bus_resp_err_i;

  assign head_buf = ent_buf[core_rd_q];

  // A non-bufferable head may only answer once the bus has caught up with it.
  always_comb begin
    resp_valid = 1'b0;
    if (!rst && (core_cnt_q != '0)) begin
      resp_valid = head_buf ? 1'b1 : ((bus_rd_q == core_rd_q) && bus_resp_valid_i);
    end
  end

  assign resp_fwd          = resp_valid && !head_buf;
  assign core_resp_valid_o = resp_valid;
  assign core_resp_rdata_o = resp_fwd ? bus_resp_rdata_i : 32'h0;
  assign core_resp_err_o   = resp_fwd && bus_resp_err_i;
  assign core_resp_store_o = ent_we[core_rd_q];
  assign core_resp_meta_o  = ent_meta[core_rd_q];

  assign bus_busy_o     = (bus_cnt_q != '0);
  assign busy_o         = bus_busy_o || (!rst && core_req_valid_i);
  assign wr_err_valid_o = wr_err_valid_q;
  assign wr_err_addr_o  = wr_err_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      core_rd_q      <= '0;
      bus_rd_q       <= '0;
      bus_cnt_q      <= '0;
      core_cnt_q     <= '0;
      wr_err_valid_q <= 1'b0;
      wr_err_addr_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_buf[i]  <= 1'b0;
        ent_we[i]   <= 1'b0;
        ent_addr[i] <= '0;
        ent_meta[i] <= '0;
      end
    end else begin
      if (accept) begin
        ent_buf[wr_ptr_q]  <= core_req_bufferable_i && early_ack_en_i;
        ent_we[wr_ptr_q]   <= core_req_we_i;
        ent_addr[wr_ptr_q] <= core_req_addr_i;
        ent_meta[wr_ptr_q] <= core_req_meta_i;
        wr_ptr_q           <= ptr_inc(wr_ptr_q);
      end
      if (bus_retire) bus_rd_q <= ptr_inc(bus_rd_q);
      if (resp_valid) core_rd_q <= ptr_inc(core_rd_q);

      if (accept && !bus_retire)      bus_cnt_q <= bus_cnt_q + ONE_CNT;
      else if (!accept && bus_retire) bus_cnt_q <= bus_cnt_q - ONE_CNT;

      if (accept && !resp_valid)      core_cnt_q <= core_cnt_q + ONE_CNT;
      else if (!accept && resp_valid) core_cnt_q <= core_cnt_q - ONE_CNT;

      // A fresh error outranks a simultaneous clear; later errors wait until cleared.
      if (absorb_err && !wr_err_valid_q) begin
        wr_err_valid_q <= 1'b1;
        wr_err_addr_q  <= ent_addr[bus_rd_q];
      end else if (wr_err_clear_i) begin
        wr_err_valid_q <= 1'b0;
      end
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(bus_resp_valid_i && (bus_cnt_q == '0)));
  a_core_not_behind_bus: assert property (@(posedge clk) disable iff (rst)
    core_cnt_q <= bus_cnt_q);
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    bus_cnt_q <= FULL_CNT);

endmodule
